// File: rtl/fp32_mul_responder.sv
// rtl/fp32_mul_responder.sv - fp32 multiply responder: trig/vld handshake, iterative shift-add, RNE
// Normal operands go through MUL/NORM/ROUND; zero, denormal, Inf and NaN operands take the SPEC shortcut.
module fp32_mul_responder #(
  parameter int BITS_PER_CYC = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic        trig,
  output logic [31:0] data_out,
  output logic        vld,
  output logic        busy
);

  localparam int N = 24 / BITS_PER_CYC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SPEC,
    S_NORM,
    S_ROUND
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [47:0]        r_mcand;
  logic [23:0]        r_mplier;
  logic [47:0]        r_prod;
  logic [4:0]         r_cnt;
  logic [31:0]        r_spec_res;
  logic [22:0]        r_frac;
  logic               r_guard;
  logic               r_sticky;

  // Operand classification
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [22:0]        w_fa;
  logic [22:0]        w_fb;
  logic               w_sign;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_is_spec;
  logic [31:0]        w_spec_res;
  logic signed [9:0]  w_exp_cap;

  assign w_ea      = data1_in[30:23];
  assign w_eb      = data2_in[30:23];
  assign w_fa      = data1_in[22:0];
  assign w_fb      = data2_in[22:0];
  assign w_sign    = data1_in[31] ^ data2_in[31];
  assign w_a_zero  = (w_ea == 8'h00);
  assign w_b_zero  = (w_eb == 8'h00);
  assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_is_spec = w_a_zero | w_b_zero | (w_ea == 8'hFF) | (w_eb == 8'hFF);
  assign w_exp_cap = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  always_comb begin
    w_spec_res = {w_sign, 31'd0};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_res = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
    end
  end

  // Shift-add step: retire BITS_PER_CYC multiplier LSBs per cycle
  logic [47:0] w_acc;

  always_comb begin
    w_acc = r_prod;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (r_mplier[i]) begin
        w_acc = w_acc + (r_mcand << i);
      end
    end
  end

  // Normalisation of the 48-bit product (always in [1,4) for normal operands)
  logic [22:0]        w_norm_frac;
  logic               w_norm_guard;
  logic               w_norm_sticky;
  logic signed [9:0]  w_norm_exp;

  always_comb begin
    if (r_prod[47]) begin
      w_norm_frac   = r_prod[46:24];
      w_norm_guard  = r_prod[23];
      w_norm_sticky = |r_prod[22:0];
      w_norm_exp    = r_exp + 10'sd1;
    end else begin
      w_norm_frac   = r_prod[45:23];
      w_norm_guard  = r_prod[22];
      w_norm_sticky = |r_prod[21:0];
      w_norm_exp    = r_exp;
    end
  end

  // Round to nearest even; a carry out of the fraction leaves frac=0 and bumps the exponent
  logic               w_inc;
  logic [23:0]        w_sum;
  logic signed [9:0]  w_exp_fin;
  logic [31:0]        w_round_res;

  always_comb begin
    w_inc     = r_guard & (r_sticky | r_frac[0]);
    w_sum     = {1'b0, r_frac} + {23'd0, w_inc};
    w_exp_fin = w_sum[23] ? (r_exp + 10'sd1) : r_exp;
    if (w_exp_fin >= 10'sd255) begin
      w_round_res = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_fin <= 10'sd0) begin
      w_round_res = {r_sign, 31'd0};
    end else begin
      w_round_res = {r_sign, w_exp_fin[7:0], w_sum[22:0]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (trig) w_next = w_is_spec ? S_SPEC : S_MUL;
      S_MUL:   if (r_cnt == 5'(N - 1)) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_IDLE;
      S_SPEC:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sign     <= 1'b0;
      r_exp      <= 10'sd0;
      r_mcand    <= 48'd0;
      r_mplier   <= 24'd0;
      r_prod     <= 48'd0;
      r_cnt      <= 5'd0;
      r_spec_res <= 32'd0;
      r_frac     <= 23'd0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      data_out   <= 32'd0;
      vld        <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (trig) begin
            r_sign     <= w_sign;
            r_exp      <= w_exp_cap;
            r_mcand    <= {24'd0, 1'b1, w_fa};
            r_mplier   <= {1'b1, w_fb};
            r_prod     <= 48'd0;
            r_cnt      <= 5'd0;
            r_spec_res <= w_spec_res;
          end
        end
        S_MUL: begin
          r_prod   <= w_acc;
          r_mcand  <= r_mcand << BITS_PER_CYC;
          r_mplier <= r_mplier >> BITS_PER_CYC;
          r_cnt    <= r_cnt + 5'd1;
        end
        S_NORM: begin
          r_frac   <= w_norm_frac;
          r_guard  <= w_norm_guard;
          r_sticky <= w_norm_sticky;
          r_exp    <= w_norm_exp;
        end
        S_ROUND: begin
          data_out <= w_round_res;
          vld      <= 1'b1;
        end
        S_SPEC: begin
          data_out <= r_spec_res;
          vld      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp32_mul_responder.sv
// tb/tb_fp32_mul_responder.sv - directed vector bench for fp32_mul_responder (BITS_PER_CYC 1 and 4)
module tb_fp32_mul_responder;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] a, b;
  logic        trig1, trig4;
  logic [31:0] out1, out4;
  logic        vld1, vld4, busy1, busy4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  fp32_mul_responder #(.BITS_PER_CYC(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data1_in(a), .data2_in(b),
    .trig(trig1), .data_out(out1), .vld(vld1), .busy(busy1)
  );

  fp32_mul_responder #(.BITS_PER_CYC(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data1_in(a), .data2_in(b),
    .trig(trig4), .data_out(out4), .vld(vld4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        spec;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_vld(input int sel);
    return (sel == 1) ? vld1 : vld4;
  endfunction

  function automatic logic [31:0] get_out(input int sel);
    return (sel == 1) ? out1 : out4;
  endfunction

  // Called at a negedge; drives trig for one cycle and returns at the negedge of cycle c+1
  task automatic pulse(input int sel, input logic [31:0] xa, input logic [31:0] xb);
    a = xa;
    b = xb;
    if (sel == 1) trig1 = 1'b1; else trig4 = 1'b1;
    @(negedge sys_clk);
    trig1 = 1'b0;
    trig4 = 1'b0;
  endtask

  task automatic wait_vld(input int sel, input int start, output int lat);
    lat = start;
    while (!get_vld(sel) && lat < 80) begin
      @(negedge sys_clk);
      lat++;
    end
  endtask

  task automatic run_op(input int sel, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] expv, input int explat, input string name);
    int lat;
    @(negedge sys_clk);
    pulse(sel, xa, xb);
    wait_vld(sel, 1, lat);
    check({name, "_lat"}, 32'(lat), 32'(explat));
    check({name, "_data"}, get_out(sel), expv);
    @(negedge sys_clk);
    check({name, "_vld_once"}, {31'd0, get_vld(sel)}, 32'd0);
  endtask

  initial begin
    int lat;
    int nv;

    tbl[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0};
    tbl[1]  = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 1'b0};
    tbl[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0};
    tbl[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0};
    tbl[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0};
    tbl[5]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b1};
    tbl[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1};
    tbl[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1};
    tbl[8]  = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b1};
    tbl[9]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};
    tbl[10] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0};
    tbl[11] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0};
    tbl[12] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 1'b0};
    tbl[13] = '{32'h80400000, 32'h40000000, 32'h80000000, 1'b1};
    tbl[14] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0};
    tbl[15] = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0};
    tbl[16] = '{32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 1'b0};
    tbl[17] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0};
    tbl[18] = '{32'hFFC00001, 32'h7F800000, 32'h7FC00000, 1'b1};
    tbl[19] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b1};

    a = 32'd0;
    b = 32'd0;
    trig1 = 1'b0;
    trig4 = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_data", out1, 32'd0);
    check("rst_vld", {31'd0, vld1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_op(1, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].spec ? 2 : 27, $sformatf("v%0d_n1", i));
    end
    for (int i = 0; i < 20; i++) begin
      run_op(4, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].spec ? 2 : 9, $sformatf("v%0d_n4", i));
    end

    // Second trig while busy is ignored
    @(negedge sys_clk);
    pulse(1, 32'h3FC00000, 32'h40000000);
    check("busy_c1", {31'd0, busy1}, 32'd1);
    repeat (3) @(negedge sys_clk);
    @(negedge sys_clk);
    a = 32'h40400000;
    b = 32'h40400000;
    trig1 = 1'b1;
    @(negedge sys_clk);
    trig1 = 1'b0;
    wait_vld(1, 6, lat);
    check("ign_lat", 32'(lat), 32'd27);
    check("ign_data", out1, 32'h40400000);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sys_clk);
      if (vld1) nv++;
    end
    check("ign_extra_vld", 32'(nv), 32'd0);

    // Back-to-back: trig in the vld cycle
    for (int s = 0; s < 2; s++) begin
      int sel;
      int nlat;
      sel  = (s == 0) ? 1 : 4;
      nlat = (s == 0) ? 27 : 9;
      @(negedge sys_clk);
      pulse(sel, 32'h3FC00000, 32'h40000000);
      wait_vld(sel, 1, lat);
      check($sformatf("b2b_first_lat_%0d", sel), 32'(lat), 32'(nlat));
      check($sformatf("b2b_first_data_%0d", sel), get_out(sel), 32'h40400000);
      check($sformatf("b2b_busy_vld_%0d", sel), {31'd0, (sel == 1) ? busy1 : busy4}, 32'd0);
      pulse(sel, 32'hC0400000, 32'h40000000);
      check($sformatf("b2b_no_double_vld_%0d", sel), {31'd0, get_vld(sel)}, 32'd0);
      wait_vld(sel, 1, lat);
      check($sformatf("b2b_second_lat_%0d", sel), 32'(lat), 32'(nlat));
      check($sformatf("b2b_second_data_%0d", sel), get_out(sel), 32'hC0C00000);
    end

    // Reset mid-operation aborts it
    @(negedge sys_clk);
    pulse(1, 32'h3F800000, 32'h40000000);
    repeat (9) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("rstmid_vld", {31'd0, vld1}, 32'd0);
    check("rstmid_busy", {31'd0, busy1}, 32'd0);
    check("rstmid_data", out1, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sys_clk);
      if (vld1) nv++;
    end
    check("rstmid_no_vld", 32'(nv), 32'd0);
    run_op(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 27, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
